// File: rtl/nn_pkg.sv
// Shared constants and types for the fixed-point neuron MAC and its
// fixed-point to FP16 converter.
package nn_pkg;

  // Q8.8 operand fractional bits; products and the accumulator carry twice that.
  localparam int FRAC     = 8;
  localparam int ACC_FRAC = 2 * FRAC;

  // IEEE-754 binary16 constants.
  localparam logic [15:0] FP16_MAX_POS = 16'h7BFF;
  localparam logic [15:0] FP16_MAX_NEG = 16'hFBFF;
  localparam logic [15:0] FP16_ONE     = 16'h3C00;
  localparam int          EXP_BIAS     = 15;

  // Leading-one positions (in the Q.16 accumulator) bounding the normal range:
  // below MIN_POS the value is under 2^-14, above MAX_POS it is >= 2^16.
  localparam int MIN_POS = ACC_FRAC - EXP_BIAS + 1;
  localparam int MAX_POS = ACC_FRAC + EXP_BIAS;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC   = 3'd1,
    CONV1 = 3'd2,
    CONV2 = 3'd3,
    HOLD  = 3'd4
  } state_e;

endpackage

// File: rtl/fx2fp16.sv
// Two-stage signed Q.16 fixed-point to IEEE-754 binary16 converter.
// Stage 1 (conv1_i) captures sign, magnitude and leading-one position;
// stage 2 (conv2_i) packs the result, truncating toward zero, flushing
// values below 2^-14 to zero and saturating at +/-65504.
module fx2fp16
  import nn_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    conv1_i,
  input  logic                    conv2_i,
  input  logic signed [ACC_W-1:0] acc_i,
  output logic [15:0]             fp16_o,
  output logic                    sat_o
);

  localparam int POS_W = $clog2(ACC_W);

  logic             sign_q, sign_d;
  logic [ACC_W-1:0] abs_q, abs_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             nz_q, nz_d;
  logic [15:0]      fp16_q, fp16_d;
  logic             sat_q, sat_d;

  logic [ACC_W-1:0] abs_s;
  logic [POS_W-1:0] pos_s;
  logic [POS_W-1:0] shamt_s;
  logic [ACC_W-1:0] norm_s;
  logic [9:0]       mant_s;
  logic [4:0]       exp_s;
  int               pos_int_s;
  logic [15:0]      pack_s;
  logic             pack_sat_s;

  // Stage 1: magnitude and leading-one detect of the incoming sum.
  always_comb begin
    abs_s = acc_i[ACC_W-1] ? $unsigned(-acc_i) : $unsigned(acc_i);
    pos_s = {POS_W{1'b0}};
    for (int i = 0; i < ACC_W; i++) begin
      pos_s = abs_s[i] ? POS_W'(i) : pos_s;
    end
    if (conv1_i) begin
      sign_d = acc_i[ACC_W-1];
      abs_d  = abs_s;
      pos_d  = pos_s;
      nz_d   = |abs_s;
    end else begin
      sign_d = sign_q;
      abs_d  = abs_q;
      pos_d  = pos_q;
      nz_d   = nz_q;
    end
  end

  // Stage 2: normalise, then pack with flush-to-zero and saturation.
  always_comb begin
    pos_int_s = int'(pos_q);
    shamt_s   = POS_W'(ACC_W - 1) - pos_q;
    norm_s    = abs_q << shamt_s;
    mant_s    = norm_s[ACC_W-2 -: 10];
    exp_s     = 5'(pos_int_s - ACC_FRAC + EXP_BIAS);
    if (!nz_q || (pos_int_s < MIN_POS)) begin
      pack_s     = 16'h0000;
      pack_sat_s = 1'b0;
    end else if ((pos_int_s > MAX_POS) ||
                 ((pos_int_s == MAX_POS) && (mant_s == 10'h3FF))) begin
      pack_s     = sign_q ? FP16_MAX_NEG : FP16_MAX_POS;
      pack_sat_s = 1'b1;
    end else begin
      pack_s     = {sign_q, exp_s, mant_s};
      pack_sat_s = 1'b0;
    end
    if (conv2_i) begin
      fp16_d = pack_s;
      sat_d  = pack_sat_s;
    end else begin
      fp16_d = fp16_q;
      sat_d  = sat_q;
    end
  end

  // Pipeline and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_q <= 1'b0;
      abs_q  <= {ACC_W{1'b0}};
      pos_q  <= {POS_W{1'b0}};
      nz_q   <= 1'b0;
      fp16_q <= 16'h0000;
      sat_q  <= 1'b0;
    end else begin
      sign_q <= sign_d;
      abs_q  <= abs_d;
      pos_q  <= pos_d;
      nz_q   <= nz_d;
      fp16_q <= fp16_d;
      sat_q  <= sat_d;
    end
  end

  assign fp16_o = fp16_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/neuron_mac_fp16.sv
// Neuron multiply-accumulate: streams Q8.8 activation/weight beats into a
// signed Q24.16 accumulator, then converts the sum to binary16 for the
// sigmoid stage. Optional bias input is enabled by NEURON_MAC_BIAS_EN.
module neuron_mac_fp16
  import nn_pkg::*;
#(
  parameter int N_INPUTS = 16,
  parameter int ACC_W    = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] w_in,
`ifdef NEURON_MAC_BIAS_EN
  input  logic signed [15:0] bias_in,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        NEURON_SIGNAL,
  output logic               sat,
  output logic               cnt_err
);

  localparam int CNT_W = $clog2(N_INPUTS + 1);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    cnt_err_q, cnt_err_d;

  logic                    beat_s;
  logic signed [31:0]      prod_s;
  logic signed [ACC_W-1:0] prod_ext_s;
  logic signed [ACC_W-1:0] init_s;
  logic signed [ACC_W-1:0] sum_base_s;
  logic [CNT_W-1:0]        beat_cnt_s;
  logic                    full_s;
  logic                    conv1_s;
  logic                    conv2_s;

  assign beat_s     = in_valid && in_ready_q;
  assign prod_s     = x_in * w_in;
  assign prod_ext_s = {{(ACC_W-32){prod_s[31]}}, prod_s};

`ifdef NEURON_MAC_BIAS_EN
  // Bias is Q8.8; shifting by 8 aligns it to the Q.16 accumulator.
  assign init_s = {{(ACC_W-24){bias_in[15]}}, bias_in, 8'h00};
`else
  assign init_s = {ACC_W{1'b0}};
`endif

  // A beat in IDLE starts a fresh sum; in ACC it extends the running one.
  always_comb begin
    if (state_q == IDLE) begin
      sum_base_s = init_s;
      beat_cnt_s = CNT_W'(1);
    end else begin
      sum_base_s = acc_q;
      beat_cnt_s = cnt_q + CNT_W'(1);
    end
    full_s = (beat_cnt_s == CNT_W'(N_INPUTS));
  end

  // Next-state, datapath and handshake logic.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    conv1_s   = 1'b0;
    conv2_s   = 1'b0;
    case (state_q)
      IDLE, ACC: begin
        if (beat_s) begin
          acc_d = sum_base_s + prod_ext_s;
          cnt_d = beat_cnt_s;
          if (in_last || full_s) begin
            state_d = CONV1;
            err_d   = full_s && !in_last;
          end else begin
            state_d = ACC;
            err_d   = 1'b0;
          end
        end else begin
          state_d = state_q;
        end
      end
      CONV1: begin
        conv1_s = 1'b1;
        state_d = CONV2;
      end
      CONV2: begin
        conv2_s = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
          acc_d   = {ACC_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = {ACC_W{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
    in_ready_d  = (state_d == IDLE) || (state_d == ACC);
    out_valid_d = (state_d == HOLD);
    cnt_err_d   = conv2_s ? err_q : cnt_err_q;
  end

  // State, accumulator and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_err_q   <= cnt_err_d;
    end
  end

  fx2fp16 #(
    .ACC_W (ACC_W)
  ) u_fx2fp16 (
    .clk     (clk),
    .rst     (rst),
    .conv1_i (conv1_s),
    .conv2_i (conv2_s),
    .acc_i   (acc_q),
    .fp16_o  (NEURON_SIGNAL),
    .sat_o   (sat)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign cnt_err   = cnt_err_q;

endmodule

// File: tb/tb_neuron_mac_fp16.sv
// Directed self-checking bench for neuron_mac_fp16 (default build, and with
// NEURON_MAC_BIAS_EN the bias is tied to zero so expectations are unchanged).
module tb_neuron_mac_fp16;
  import nn_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [15:0] x_in;
  logic [15:0] w_in;
`ifdef NEURON_MAC_BIAS_EN
  logic [15:0] bias_in;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] NEURON_SIGNAL;
  logic        sat;
  logic        cnt_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  neuron_mac_fp16 #(.N_INPUTS(16), .ACC_W(40)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_last       (in_last),
    .x_in          (x_in),
    .w_in          (w_in),
`ifdef NEURON_MAC_BIAS_EN
    .bias_in       (bias_in),
`endif
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .NEURON_SIGNAL (NEURON_SIGNAL),
    .sat           (sat),
    .cnt_err       (cnt_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic beat(input logic [15:0] x, input logic [15:0] w, input logic last);
    int waited = 0;
    in_valid = 1'b1;
    x_in     = x;
    w_in     = w;
    in_last  = last;
    while (!in_ready && waited < 40) begin
      tick();
      waited++;
    end
    chk("beat_ready", {15'd0, in_ready}, 16'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the last-beat edge: checks latency, value, hold, handshake.
  task automatic result(input string tag, input logic [15:0] sig, input logic s,
                        input logic e, input int hold);
    chk({tag, "_lat1"}, {15'd0, out_valid}, 16'd0);
    tick();
    chk({tag, "_lat2"}, {15'd0, out_valid}, 16'd0);
    tick();
    chk({tag, "_lat3"}, {15'd0, out_valid}, 16'd1);
    chk({tag, "_sig"}, NEURON_SIGNAL, sig);
    chk({tag, "_sat"}, {15'd0, sat}, {15'd0, s});
    chk({tag, "_err"}, {15'd0, cnt_err}, {15'd0, e});
    chk({tag, "_rdy"}, {15'd0, in_ready}, 16'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_sig"}, NEURON_SIGNAL, sig);
      chk({tag, "_hold_val"}, {15'd0, out_valid}, 16'd1);
      chk({tag, "_hold_rdy"}, {15'd0, in_ready}, 16'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_done_val"}, {15'd0, out_valid}, 16'd0);
    chk({tag, "_done_rdy"}, {15'd0, in_ready}, 16'd1);
  endtask

  task automatic run(input string tag, input int n, input logic [15:0] x,
                     input logic [15:0] w, input logic [15:0] sig, input logic s);
    for (int i = 0; i < n; i++) begin
      beat(x, w, i == n - 1);
    end
    result(tag, sig, s, 1'b0, 0);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    x_in      = 16'h0000;
    w_in      = 16'h0000;
    out_ready = 1'b0;
`ifdef NEURON_MAC_BIAS_EN
    bias_in   = 16'h0000;
`endif
    #1;
    chk("rst_ready", {15'd0, in_ready}, 16'd0);
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_sig", NEURON_SIGNAL, 16'h0000);
    chk("rst_sat", {15'd0, sat}, 16'd0);
    chk("rst_err", {15'd0, cnt_err}, 16'd0);
    tick();
    rst = 1'b1;
    chk("rel_ready_low", {15'd0, in_ready}, 16'd0);
    tick();
    chk("rel_ready_high", {15'd0, in_ready}, 16'd1);

    // 4 x (1.0 * 1.0) = 4.0
    run("four", 4, 16'h0100, 16'h0100, 16'h4400, 1'b0);
    // -2.0 * 0.5 = -1.0
    run("neg1", 1, 16'hFE00, 16'h0080, 16'hBC00, 1'b0);
    // 16 x ~16384 saturates positive
    run("satp", 16, 16'h7FFF, 16'h7FFF, FP16_MAX_POS, 1'b1);
    // 2^-16 flushes, x*0 is zero
    run("flush", 1, 16'h0001, 16'h0001, 16'h0000, 1'b0);
    run("zero", 1, 16'h0100, 16'h0000, 16'h0000, 1'b0);
    // 4 * 2^-16 = 2^-14 smallest normal; 3 * 2^-16 flushes
    run("minnorm", 1, 16'h0002, 16'h0002, 16'h0400, 1'b0);
    run("subnorm", 1, 16'h0003, 16'h0001, 16'h0000, 1'b0);
    // 8 x 8184 = 65472 largest non-saturating; 8 x 8188 = 65504 saturates
    run("below_max", 8, 16'h7FE0, 16'h4000, 16'h7BFE, 1'b0);
    run("at_max", 8, 16'h7FF0, 16'h4000, FP16_MAX_POS, 1'b1);
    // 257^2 / 2^16 = 1.00784..: mantissa truncates to 0x008 for either sign
    run("trunc_p", 1, 16'h0101, 16'h0101, 16'h3C08, 1'b0);
    run("trunc_n", 1, 16'hFEFF, 16'h0101, 16'hBC08, 1'b0);
    // Large negative saturation
    run("satn", 16, 16'h8000, 16'h7FFF, FP16_MAX_NEG, 1'b1);

    // 16 beats without last: terminates with cnt_err, beat 17 waits
    for (int i = 0; i < 16; i++) begin
      beat(16'h0100, 16'h0100, 1'b0);
    end
    in_valid = 1'b1;
    x_in     = 16'h0200;
    w_in     = 16'h0100;
    in_last  = 1'b1;
    chk("cnt_c1_rdy", {15'd0, in_ready}, 16'd0);
    tick();
    chk("cnt_c2_rdy", {15'd0, in_ready}, 16'd0);
    tick();
    chk("cnt_val", {15'd0, out_valid}, 16'd1);
    chk("cnt_rdy", {15'd0, in_ready}, 16'd0);
    chk("cnt_sig", NEURON_SIGNAL, 16'h4C00);
    chk("cnt_sat", {15'd0, sat}, 16'd0);
    chk("cnt_err", {15'd0, cnt_err}, 16'd1);
    tick();
    chk("cnt_hold_sig", NEURON_SIGNAL, 16'h4C00);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("cnt_done_val", {15'd0, out_valid}, 16'd0);
    chk("b17_ready", {15'd0, in_ready}, 16'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    result("b17", 16'h4000, 1'b0, 1'b0, 0);

    // -1.5 + 0.25 = -1.25, output held 5 cycles with out_ready low
    beat(16'h0180, 16'hFF00, 1'b0);
    beat(16'h0040, 16'h0100, 1'b1);
    result("hold", 16'hBD00, 1'b0, 1'b0, 5);

    // Reset mid-ACC discards the partial 8.0
    beat(16'h0400, 16'h0100, 1'b0);
    beat(16'h0400, 16'h0100, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {15'd0, in_ready}, 16'd0);
    chk("mid_rst_valid", {15'd0, out_valid}, 16'd0);
    chk("mid_rst_sig", NEURON_SIGNAL, 16'h0000);
    chk("mid_rst_sat", {15'd0, sat}, 16'd0);
    chk("mid_rst_err", {15'd0, cnt_err}, 16'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rel_ready", {15'd0, in_ready}, 16'd1);
    run("post_rst", 1, 16'h0100, 16'h0100, FP16_ONE, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/neuron_mac_fp16.md
NEURON_MAC_FP16 -- requirements
Module: neuron_mac_fp16

Interface
REQ-001 SHALL have parameter N_INPUTS, default 16, the maximum number of multiply beats per neuron.
REQ-002 SHALL have parameter ACC_W, default 40, the signed accumulator width in Q24.16.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the beat is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a beat.
REQ-007 SHALL have port in_last, input, 1 bit: final beat of the neuron.
REQ-008 SHALL have port x_in, input, 16 bits: activation, signed Q8.8.
REQ-009 SHALL have port w_in, input, 16 bits: weight, signed Q8.8.
REQ-010 SHALL have port bias_in, input, 16 bits: bias, signed Q8.8, present only with NEURON_MAC_BIAS_EN.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port NEURON_SIGNAL, output, 16 bits: result as IEEE-754 binary16, feeding the sigmoid stage's NEURON_SIGNAL_IN.
REQ-014 SHALL have port sat, output, 1 bit: the result was saturated.
REQ-015 SHALL have port cnt_err, output, 1 bit: N_INPUTS beats were accepted without in_last.

Function
REQ-016 SHALL use an FSM with states IDLE, ACC, CONV1, CONV2 and HOLD.
REQ-017 SHALL count a beat as accepted when in_valid and in_ready are both high on a rising edge.
REQ-018 SHALL drive in_ready high only in IDLE and ACC.
REQ-019 SHALL, on the first accepted beat in IDLE, initialise the accumulator to the bias (or 0) plus x_in*w_in and go to ACC.
REQ-020 SHALL form each product as a signed 32-bit Q16.16 value, sign-extend it to ACC_W and add it with no intermediate truncation.
REQ-021 SHALL leave ACC for CONV1 on an accepted beat with in_last=1, or on the N_INPUTS-th accepted beat.
REQ-022 SHALL set cnt_err for the result when the N_INPUTS-th beat is accepted with in_last=0.
REQ-023 SHALL, in CONV1, register the sign, the absolute value and the leading-one position.
REQ-024 SHALL, in CONV2, pack exponent = position - 16 + 15 and the 10-bit mantissa, truncating toward zero.
REQ-025 SHALL output 0x0000 for a zero sum, and for |sum| < 2^-14 (flush to zero, no subnormals).
REQ-026 SHALL output 0x7BFF (positive) or 0xFBFF (negative) with sat=1 when |sum| >= 65504.
REQ-027 SHALL assert out_valid in the third cycle after the last-beat handshake cycle (CONV1, CONV2, then HOLD).
REQ-028 SHALL hold NEURON_SIGNAL, sat and cnt_err stable in HOLD until out_valid and out_ready are both high.
REQ-029 SHALL go to IDLE on the output handshake, with in_ready high in the following cycle.
REQ-030 SHALL ignore in_valid while in CONV1, CONV2 or HOLD.

Reset
REQ-031 SHALL, while rst=0, immediately force the state to IDLE, clear the accumulator and counter, and drive in_ready=0, out_valid=0, NEURON_SIGNAL=0x0000, sat=0 and cnt_err=0.
REQ-032 SHALL discard a partial sum on reset mid-operation, and assert in_ready on the first clock edge after rst deasserts.

Configuration
REQ-033 SHALL, with NEURON_MAC_BIAS_EN defined, expose bias_in, sample it on the first accepted beat and add bias_in<<8 into the accumulator initialisation.
REQ-034 SHALL, without NEURON_MAC_BIAS_EN, omit bias_in and initialise the accumulator to 0.

Structure
REQ-035 SHALL place the FP16 constants (FP16_MAX_POS=0x7BFF, FP16_MAX_NEG=0xFBFF, FP16_ONE=0x3C00, EXP_BIAS=15), the Q8.8 FRAC=8 constant and the FSM state enum in the shared package nn_pkg.
REQ-036 SHALL contain one sub-module, fx2fp16 (CONV1/CONV2 leading-one detect and pack), instantiated once.

Verification
REQ-037 SHALL test: 4 beats of x=0x0100, w=0x0100, last on beat 4 -> NEURON_SIGNAL=0x4400, sat=0, out_valid 3 cycles after the last beat.
REQ-038 SHALL test: 1 beat of x=0xFE00, w=0x0080, in_last=1 -> 0xBC00.
REQ-039 SHALL test: 16 beats of x=0x7FFF, w=0x7FFF, last on beat 16 -> 0x7BFF, sat=1, cnt_err=0.
REQ-040 SHALL test: x=0x0001, w=0x0001 single beat -> 0x0000 (flush); x=0x0100, w=0x0000 -> 0x0000.
REQ-041 SHALL test: 16 beats with in_last=0 -> terminates after beat 16, cnt_err=1, beat 17 not accepted until after the output handshake.
REQ-042 SHALL test: out_ready low for 5 cycles -> output stable and in_ready=0; rst pulled low mid-ACC -> all outputs 0, and the next neuron's result excludes the old partial sum.
